// File: rtl/serializer_piso.sv
// Parallel-in/serial-out stage: takes an N-bit word over valid/ready and emits one bit per clock.
// Define SERIALIZER_PARITY_EN to append one even-parity bit to every frame.
module serializer_piso #(
    parameter int N         = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         frame_done
);

`ifdef SERIALIZER_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(L - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
    logic [N-1:0]  shreg_q, shreg_n;
    logic          sout_n, valid_n, fd_n;
    logic          last_bit, accept;
`ifdef SERIALIZER_PARITY_EN
    logic          par_q, par_n;
`endif

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign in_ready = !rst && ((state_q == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    // Outputs are computed one cycle ahead so sout/flags come straight from flops.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        shreg_n = shreg_q;
        cnt_inc = cnt_q + 1'b1;
        sout_n  = 1'b0;
        valid_n = 1'b0;
        fd_n    = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_n   = par_q;
`endif
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            valid_n = 1'b1;
            sout_n  = MSB_FIRST ? in_data[N-1] : in_data[0];
            shreg_n = MSB_FIRST ? {in_data[N-2:0], 1'b0} : {1'b0, in_data[N-1:1]};
`ifdef SERIALIZER_PARITY_EN
            par_n   = ^in_data;
`endif
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_n = IDLE;
                cnt_n   = '0;
                shreg_n = '0;
            end else begin
                cnt_n   = cnt_inc;
                valid_n = 1'b1;
                fd_n    = (cnt_inc == LAST_IDX);
                sout_n  = MSB_FIRST ? shreg_q[N-1] : shreg_q[0];
                shreg_n = MSB_FIRST ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
`ifdef SERIALIZER_PARITY_EN
                if (cnt_inc == CW'(N)) begin
                    sout_n = par_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            shreg_q    <= shreg_n;
            sout       <= sout_n;
            sout_valid <= valid_n;
            busy       <= (state_n == SHIFT);
            frame_done <= fd_n;
`ifdef SERIALIZER_PARITY_EN
            par_q      <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_serializer_piso.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) driven with the same words;
// a monitor pops expected bits from per-DUT queues each cycle.
module tb_serializer_piso;
    localparam int N = 32;
`ifdef SERIALIZER_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         rdy_m, sout_m, sv_m, busy_m, fd_m;
    logic         rdy_l, sout_l, sv_l, busy_l, fd_l;

    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    logic [1:0]   q_m[$];
    logic [1:0]   q_l[$];

    always #5 clk = ~clk;

    serializer_piso #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .frame_done(fd_m)
    );

    serializer_piso #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .frame_done(fd_l)
    );

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame: payload bits in transmit order, then parity; {bit, last_flag}.
    task automatic push_frame(input logic [N-1:0] w);
        logic bm, bl;
        for (int i = 0; i < L; i++) begin
            if (i < N) begin
                bm = w[N-1-i];
                bl = w[i];
            end else begin
                bm = ^w;
                bl = ^w;
            end
            q_m.push_back({bm, 1'(i == L - 1)});
            q_l.push_back({bl, 1'(i == L - 1)});
        end
    endtask

    initial begin
        logic [1:0] e_m, e_l;
        logic       have_m, have_l, exp_rdy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_rdy = !rst && (q_m.size() <= 1);
            check("in_ready_msb", rdy_m, exp_rdy);
            check("in_ready_lsb", rdy_l, exp_rdy);
            have_m = (q_m.size() != 0);
            have_l = (q_l.size() != 0);
            e_m = have_m ? q_m.pop_front() : 2'b00;
            e_l = have_l ? q_l.pop_front() : 2'b00;
            check("sout_valid_msb", sv_m, have_m);
            check("sout_msb", sout_m, e_m[1]);
            check("frame_done_msb", fd_m, e_m[0]);
            check("busy_msb", busy_m, have_m);
            check("sout_valid_lsb", sv_l, have_l);
            check("sout_lsb", sout_l, e_l[1]);
            check("frame_done_lsb", fd_l, e_l[0]);
            check("busy_lsb", busy_l, have_l);
            if (rst) begin
                q_m.delete();
                q_l.delete();
            end else if (in_valid && exp_rdy) begin
                push_frame(in_data);
            end
        end
    end

    task automatic send(input logic [N-1:0] w);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (rdy_m && !rst) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: word %h not accepted, expected accept within 200 cycles", w);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        idle(2);

        send(32'hA5A5_0001);
        idle(L + 3);
        send(32'hFFFF_FFFF);
        send(32'h0000_0000);
        idle(L + 3);

        send(32'h1234_5678);
        idle(9);
        pulse_reset();
        send(32'h8000_0000);
        idle(L + 3);

        send(32'h0000_0003);
        idle(L + 3);
        send(32'h0000_0007);
        idle(L + 3);

        for (int unsigned t = 0; t < 40; t++) begin
            int unsigned gap;
            send($urandom);
            gap = $urandom_range(0, 3);
            if (gap != 0) idle(gap);
            if ($urandom_range(0, 15) == 0) begin
                idle($urandom_range(0, L));
                pulse_reset();
            end
        end
        idle(L + 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
